// File: rtl/uart_transmitter_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_transmitter_fifo_pkg
// Brief    : Shared FSM state encoding and parity-mode constants.
// Revision : 1.0
// ============================================================================
package uart_transmitter_fifo_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    function automatic logic parity_of(input logic [7:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_transmitter_fifo_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_transmitter_fifo_byte_fifo
// Brief    : Single-clock synchronous FIFO with occupancy count.
// Revision : 1.0
// ============================================================================
module uart_transmitter_fifo_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_q == DEPTH_CNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem[rd_ptr];
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Depth is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_transmitter_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_transmitter_fifo
// Brief    : FIFO-fed UART transmitter with configurable frame and tx gate.
// Revision : 1.0
// ============================================================================
module uart_transmitter_fifo
    import uart_transmitter_fifo_pkg::*;
#(
    parameter int CLOCKS_PER_BAUD = 1250,
    parameter int DATA_BITS       = 8,
    parameter int PARITY_MODE     = 0,
    parameter int STOP_BITS       = 1,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_byte,
    input  logic                          tx_byte_valid,
    output logic                          tx_byte_ready,
    input  logic                          tx_enable,
    output logic                          tx_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
);

    localparam int BAUD_W = $clog2(CLOCKS_PER_BAUD);
    localparam logic [BAUD_W-1:0] BAUD_RELOAD   = BAUD_W'(CLOCKS_PER_BAUD - 1);
    localparam logic [2:0]        LAST_DATA_BIT = 3'(DATA_BITS - 1);
    localparam logic [2:0]        LAST_STOP_BIT = 3'(STOP_BITS - 1);
    localparam logic [7:0]        DATA_MASK     = 8'((1 << DATA_BITS) - 1);

    if (CLOCKS_PER_BAUD < 2 || DATA_BITS < 5 || DATA_BITS > 8 ||
        PARITY_MODE < 0 || PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("uart_transmitter_fifo: illegal parameter combination");
    end

    tx_state_t         state, state_d;
    logic [BAUD_W-1:0] baud_cnt, baud_cnt_d;
    logic [2:0]        bit_cnt, bit_cnt_d;
    logic [7:0]        shift_reg, shift_reg_d;
    logic              parity_bit, parity_bit_d;
    logic              tx_d;
    logic              load_frame;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]        fifo_data;
    logic              baud_done, can_start;

    assign tx_byte_ready = ~fifo_full;
    assign fifo_push     = tx_byte_valid & ~fifo_full;
    assign baud_done     = (baud_cnt == '0);
    assign can_start     = ~fifo_empty & tx_enable;
    assign busy          = (state != ST_IDLE) | ~fifo_empty;

    uart_transmitter_fifo_byte_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (tx_byte),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx_out     <= 1'b1;
        end else begin
            state      <= state_d;
            baud_cnt   <= baud_cnt_d;
            bit_cnt    <= bit_cnt_d;
            shift_reg  <= shift_reg_d;
            parity_bit <= parity_bit_d;
            tx_out     <= tx_d;
        end
    end

    // tx_d is the line level of the state being entered, so tx_out is a pure flop.
    always_comb begin
        state_d      = state;
        baud_cnt_d   = baud_cnt;
        bit_cnt_d    = bit_cnt;
        shift_reg_d  = shift_reg;
        parity_bit_d = parity_bit;
        tx_d         = tx_out;
        fifo_pop     = 1'b0;
        load_frame   = 1'b0;

        case (state)
            ST_IDLE: begin
                tx_d       = 1'b1;
                load_frame = can_start;
            end
            ST_START: begin
                if (baud_done) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    tx_d      = shift_reg[0];
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    if (bit_cnt == LAST_DATA_BIT) begin
                        if (PARITY_MODE != PARITY_NONE) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_bit;
                        end else begin
                            state_d   = ST_STOP;
                            bit_cnt_d = '0;
                            tx_d      = 1'b1;
                        end
                    end else begin
                        bit_cnt_d   = bit_cnt + 3'd1;
                        shift_reg_d = shift_reg >> 1;
                        tx_d        = shift_reg[1];
                    end
                end
            end
            ST_PARITY: begin
                if (baud_done) begin
                    state_d   = ST_STOP;
                    bit_cnt_d = '0;
                    tx_d      = 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    if (bit_cnt == LAST_STOP_BIT) begin
                        load_frame = can_start;
                        state_d    = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (state != ST_IDLE) begin
            baud_cnt_d = baud_done ? BAUD_RELOAD : baud_cnt - BAUD_W'(1);
        end

        // Shared by IDLE and the back-to-back path out of STOP.
        if (load_frame) begin
            fifo_pop     = 1'b1;
            state_d      = ST_START;
            baud_cnt_d   = BAUD_RELOAD;
            shift_reg_d  = fifo_data & DATA_MASK;
            parity_bit_d = parity_of(fifo_data & DATA_MASK, PARITY_MODE);
            tx_d         = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_transmitter_fifo
// Brief    : Self-checking bench: frame vectors, corner sequences, random traffic.
// Revision : 1.0
// ============================================================================
module tb_uart_transmitter_fifo;
    import uart_transmitter_fifo_pkg::*;

    typedef struct {
        int         sel;
        logic [7:0] data;
        int         nbits;
        logic [11:0] frame;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2:0][7:0] tx_byte_v;
    logic [2:0]      valid_v, ready_v, enable_v, tx_v, busy_v;
    logic [2:0][2:0] count_v;

    int total = 0;
    int bad   = 0;
    int guard;
    vec_t vecs [9];
    logic [7:0] burst [6];

    // Line-level reference model state (instance 0 only)
    bit         mon_en = 1'b0;
    int         fpos = -1;
    int         pushes = 0;
    int         pops = 0;
    int         model_cnt = 0;
    bit         pend = 1'b0;
    bit         saw_full = 1'b0;
    logic [7:0] pend_byte;
    logic [7:0] acc;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_transmitter_fifo #(.CLOCKS_PER_BAUD(2), .DATA_BITS(8), .PARITY_MODE(PARITY_NONE),
                            .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .tx_byte(tx_byte_v[0]), .tx_byte_valid(valid_v[0]),
        .tx_byte_ready(ready_v[0]), .tx_enable(enable_v[0]), .tx_out(tx_v[0]),
        .fifo_count(count_v[0]), .busy(busy_v[0]));

    uart_transmitter_fifo #(.CLOCKS_PER_BAUD(2), .DATA_BITS(8), .PARITY_MODE(PARITY_EVEN),
                            .STOP_BITS(2), .FIFO_DEPTH(4)) dut_even (
        .clk(clk), .rst_n(rst_n), .tx_byte(tx_byte_v[1]), .tx_byte_valid(valid_v[1]),
        .tx_byte_ready(ready_v[1]), .tx_enable(enable_v[1]), .tx_out(tx_v[1]),
        .fifo_count(count_v[1]), .busy(busy_v[1]));

    uart_transmitter_fifo #(.CLOCKS_PER_BAUD(2), .DATA_BITS(8), .PARITY_MODE(PARITY_ODD),
                            .STOP_BITS(2), .FIFO_DEPTH(4)) dut_odd (
        .clk(clk), .rst_n(rst_n), .tx_byte(tx_byte_v[2]), .tx_byte_valid(valid_v[2]),
        .tx_byte_ready(ready_v[2]), .tx_enable(enable_v[2]), .tx_out(tx_v[2]),
        .fifo_count(count_v[2]), .busy(busy_v[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] frame_8n1(input logic [7:0] b);
        return {2'b00, 1'b1, b, 1'b0};
    endfunction

    // Two samples per bit period; frame[i] is the i-th bit on the line.
    task automatic check_frame(input int sel, input logic [11:0] frame, input int nbits,
                               input string name, input int drop_at);
        for (int i = 0; i < 2 * nbits; i++) begin
            @(negedge clk);
            chk(name, tx_v[sel], frame[i / 2]);
            if (i == drop_at) enable_v[sel] = 1'b0;
        end
    endtask

    task automatic run_vector(input vec_t v);
        @(posedge clk); #1;
        tx_byte_v[v.sel] = v.data;
        valid_v[v.sel]   = 1'b1;
        @(posedge clk); #1;
        valid_v[v.sel] = 1'b0;
        @(negedge clk);
        chk("vec_pre_start", tx_v[v.sel], 1'b1);
        check_frame(v.sel, v.frame, v.nbits, "vec_frame", -1);
        @(negedge clk);
        chk("vec_end_tx", tx_v[v.sel], 1'b1);
        chk("vec_end_busy", busy_v[v.sel], 1'b0);
    endtask

    // Reference model: decodes the line, tracks queue occupancy and byte order.
    always @(negedge clk) begin
        if (mon_en) begin
            if (fpos < 0) begin
                if (tx_v[0] == 1'b0) begin
                    fpos = 0;
                    pops++;
                end
            end else begin
                fpos++;
            end
            if (pend) begin
                pushes++;
                exp_q.push_back(pend_byte);
            end
            model_cnt = pushes - pops;
            if (model_cnt == 4) saw_full = 1'b1;
            chk("mon_count", 32'(count_v[0]), model_cnt);
            chk("mon_ready", ready_v[0], model_cnt < 4);
            chk("mon_busy", busy_v[0], (fpos >= 0) || (model_cnt > 0));
            if (fpos >= 0 && fpos % 2 == 1) begin
                if (fpos == 1) begin
                    chk("mon_start", tx_v[0], 1'b0);
                end else if (fpos <= 17) begin
                    acc[fpos / 2 - 1] = tx_v[0];
                end else begin
                    chk("mon_stop", tx_v[0], 1'b1);
                    chk("mon_frame_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) chk("mon_order", acc, exp_q.pop_front());
                    fpos = -1;
                end
            end
            pend      = valid_v[0] && (model_cnt < 4);
            pend_byte = tx_byte_v[0];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 8'hA5, 10, 12'b00_1_10100101_0};
        vecs[1] = '{0, 8'h00, 10, 12'b00_1_00000000_0};
        vecs[2] = '{0, 8'hFF, 10, 12'b00_1_11111111_0};
        vecs[3] = '{1, 8'h07, 12, 12'b11_1_00000111_0};
        vecs[4] = '{2, 8'h07, 12, 12'b11_0_00000111_0};
        vecs[5] = '{1, 8'h00, 12, 12'b11_0_00000000_0};
        vecs[6] = '{2, 8'h00, 12, 12'b11_1_00000000_0};
        vecs[7] = '{1, 8'hC3, 12, 12'b11_0_11000011_0};
        vecs[8] = '{2, 8'h5B, 12, 12'b11_0_01011011_0};
        burst   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        tx_byte_v = '0;
        valid_v   = '0;
        enable_v  = '1;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("idle_tx", tx_v[0], 1'b1);
            chk("idle_busy", busy_v[0], 1'b0);
            chk("idle_ready", ready_v[0], 1'b1);
            chk("idle_count", 32'(count_v[0]), 0);
        end

        for (int i = 0; i < 9; i++) run_vector(vecs[i]);

        // Back-to-back frames, no idle gap
        @(posedge clk); #1;
        tx_byte_v[0] = 8'h0F;
        valid_v[0]   = 1'b1;
        @(posedge clk); #1;
        tx_byte_v[0] = 8'hF0;
        @(negedge clk);
        chk("b2b_pre_start", tx_v[0], 1'b1);
        @(posedge clk); #1;
        valid_v[0] = 1'b0;
        check_frame(0, frame_8n1(8'h0F), 10, "b2b_first", -1);
        check_frame(0, frame_8n1(8'hF0), 10, "b2b_second", -1);
        @(negedge clk);
        chk("b2b_busy_fall", busy_v[0], 1'b0);

        // Burst past FIFO depth, then random traffic, under the line model
        @(posedge clk); #1;
        fpos = -1; pushes = 0; pops = 0; pend = 1'b0; saw_full = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            valid_v[0]   = 1'b1;
            tx_byte_v[0] = burst[k];
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!ready_v[0] && guard < 200);
            if (guard >= 200) chk("burst_ready_timeout", 0, 1);
            @(posedge clk); #1;
        end
        valid_v[0] = 1'b0;
        chk("burst_saw_full", saw_full, 1'b1);

        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            valid_v[0]   = ($urandom_range(0, 2) != 0);
            tx_byte_v[0] = 8'($urandom);
            enable_v[0]  = ($urandom_range(0, 7) != 0);
        end
        @(posedge clk); #1;
        valid_v[0]  = 1'b0;
        enable_v[0] = 1'b1;
        repeat (2) @(posedge clk);
        guard = 0;
        while ((exp_q.size() != 0 || fpos >= 0 || pend) && guard < 1000) begin
            @(posedge clk);
            guard++;
        end
        chk("drain_in_time", guard < 1000, 1'b1);
        chk("drain_queue_empty", exp_q.size(), 0);
        @(posedge clk); #1;
        mon_en = 1'b0;

        // Reset during data bit 3 of 8'h55 with two bytes queued
        tx_byte_v[0] = 8'h55;
        valid_v[0]   = 1'b1;
        @(posedge clk); #1;
        tx_byte_v[0] = 8'hAA;
        @(posedge clk); #1;
        tx_byte_v[0] = 8'h33;
        @(posedge clk); #1;
        valid_v[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("rst_pre_tx_bit3", tx_v[0], 1'b0);
        chk("rst_pre_count", 32'(count_v[0]), 2);
        rst_n = 1'b0;
        #1;
        chk("rst_tx_high", tx_v[0], 1'b1);
        chk("rst_count_zero", 32'(count_v[0]), 0);
        chk("rst_busy_low", busy_v[0], 1'b0);
        chk("rst_ready_high", ready_v[0], 1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("post_rst_tx", tx_v[0], 1'b1);
            chk("post_rst_busy", busy_v[0], 1'b0);
        end

        // tx_enable dropped mid-frame with one byte queued
        @(posedge clk); #1;
        tx_byte_v[0] = 8'h3C;
        valid_v[0]   = 1'b1;
        @(posedge clk); #1;
        tx_byte_v[0] = 8'hC5;
        @(posedge clk); #1;
        valid_v[0] = 1'b0;
        check_frame(0, frame_8n1(8'h3C), 10, "hold_frame", 9);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_tx_high", tx_v[0], 1'b1);
        end
        chk("hold_count", 32'(count_v[0]), 1);
        chk("hold_busy", busy_v[0], 1'b1);
        @(posedge clk); #1;
        enable_v[0] = 1'b1;
        @(negedge clk);
        chk("resume_not_early", tx_v[0], 1'b1);
        check_frame(0, frame_8n1(8'hC5), 10, "resume_frame", -1);
        @(negedge clk);
        chk("resume_busy_fall", busy_v[0], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
